// File: rtl/stream_capture_buffer_pkg.sv
// rtl/stream_capture_buffer_pkg.sv - shared constants for the stream capture buffer
package stream_capture_pkg;

  localparam logic [12:0] OFF_CTRL      = 13'h000;
  localparam logic [12:0] OFF_STATUS    = 13'h004;
  localparam logic [12:0] OFF_THRESH    = 13'h008;
  localparam logic [12:0] OFF_LENGTH    = 13'h00C;
  localparam logic [12:0] OFF_TRIG_ADDR = 13'h010;
  localparam logic [12:0] BUF_BASE      = 13'h1000;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_TRIG_MODE = 3;
  localparam int STATUS_DONE    = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_POST  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;

endpackage

// File: rtl/stream_capture_buffer_if.sv
// rtl/stream_capture_buffer_if.sv - sample stream and AHB-lite slave signal bundle
interface stream_capture_buffer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tdata_s;
  logic              tvalid_s;
  logic              tready_s;
  logic [31:0]       haddr_s;
  logic [2:0]        hburst_s;
  logic [2:0]        hsize_s;
  logic [1:0]        htrans_s;
  logic [31:0]       hwdata_s;
  logic              hwrite_s;
  logic              hsel_s;
  logic [31:0]       hrdata_s;
  logic              hreadyout_s;
  logic              hresp_s;

  modport slave (
    input  tdata_s, tvalid_s, haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
    output tready_s, hrdata_s, hreadyout_s, hresp_s
  );

  modport master (
    output tdata_s, tvalid_s, haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
    input  tready_s, hrdata_s, hreadyout_s, hresp_s
  );
endinterface

// File: rtl/stream_capture_buffer_ram.sv
// rtl/stream_capture_buffer_ram.sv - simple dual-port synchronous sample RAM, read-first
module capture_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] rd_data_q;

  // Both updates are non-blocking, so a same-index read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_q <= mem[raddr];
  end

  assign rdata = rd_data_q;
endmodule

// File: rtl/stream_capture_buffer.sv
// rtl/stream_capture_buffer.sv - triggered ADC sample window capture with AHB-lite access
module stream_capture_buffer
  import stream_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  stream_capture_buffer_if.slave bus,
  output logic                   irq
);
  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] ONE_CNT   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [12:0]   BUF_TAG   = BUF_BASE >> (DEPTH_LOG2 + 2);

  logic              tready_q, tready_d;
  logic              dph_valid_q, dph_valid_d;
  logic              dph_write_q, dph_write_d;
  logic [12:0]       dph_off_q, dph_off_d;
  logic              irq_en_q, irq_en_d;
  logic              trig_mode_q, trig_mode_d;
  logic [DATA_W-1:0] thresh_q, thresh_d;
  logic [CW-1:0]     length_q, length_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic              done_q, done_d;
  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic              irq_q, irq_d;

  logic              addr_ph;
  logic              wr_en, rd_en;
  logic              ctrl_wr, status_wr, thresh_wr, length_wr;
  logic              start, abort;
  logic              accept, level_hit, trig_hit;
  logic [CW-1:0]     len_eff;
  logic [CW-1:0]     post_cnt_inc;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       hrdata;
  logic              unused_bits;

  assign addr_ph   = bus.hsel_s & bus.htrans_s[1] & bus.hreadyout_s;
  assign wr_en     = dph_valid_q & dph_write_q;
  assign rd_en     = dph_valid_q & ~dph_write_q;
  assign ctrl_wr   = wr_en & (dph_off_q == OFF_CTRL);
  assign status_wr = wr_en & (dph_off_q == OFF_STATUS);
  assign thresh_wr = wr_en & (dph_off_q == OFF_THRESH);
  assign length_wr = wr_en & (dph_off_q == OFF_LENGTH);
  assign abort     = ctrl_wr & bus.hwdata_s[CTRL_ABORT];
  assign start     = ctrl_wr & bus.hwdata_s[CTRL_START] & ~bus.hwdata_s[CTRL_ABORT];

  assign accept    = bus.tvalid_s & tready_q;
  assign level_hit = prev_valid_q & ($signed(prev_q) < $signed(thresh_q))
                   & ($signed(bus.tdata_s) >= $signed(thresh_q));
  assign trig_hit  = trig_mode_q ? level_hit : 1'b1;
  assign len_eff   = (length_q == '0 || length_q > DEPTH_CNT) ? DEPTH_CNT : length_q;
  assign post_cnt_inc = post_cnt_q + 1'b1;

  assign unused_bits = ^{bus.hburst_s, bus.hsize_s, bus.haddr_s, bus.hwdata_s};

  always_comb begin
    tready_d     = 1'b1;
    dph_valid_d  = addr_ph;
    dph_write_d  = addr_ph & bus.hwrite_s;
    dph_off_d    = bus.haddr_s[12:0];
    irq_en_d     = irq_en_q;
    trig_mode_d  = trig_mode_q;
    thresh_d     = thresh_q;
    length_d     = length_q;
    trig_addr_d  = trig_addr_q;
    done_d       = done_q;
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    post_cnt_d   = post_cnt_q;
    ram_we       = 1'b0;
    irq_d        = done_q & irq_en_q;

    if (ctrl_wr) begin
      irq_en_d    = bus.hwdata_s[CTRL_IRQ_EN];
      trig_mode_d = bus.hwdata_s[CTRL_TRIG_MODE];
    end
    if (thresh_wr) begin
      thresh_d = bus.hwdata_s[DATA_W-1:0];
    end
    if (length_wr) begin
      length_d = bus.hwdata_s[CW-1:0];
    end
    if (status_wr && bus.hwdata_s[STATUS_DONE]) begin
      done_d = 1'b0;
    end

    // A control write owns the edge; a sample arriving in that same cycle is dropped.
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d      = ST_ARMED;
      wr_ptr_d     = '0;
      prev_valid_d = 1'b0;
      post_cnt_d   = '0;
      done_d       = 1'b0;
    end else if (accept) begin
      prev_d       = bus.tdata_s;
      prev_valid_d = 1'b1;
      case (state_q)
        ST_ARMED: begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = ONE_CNT;
            if (len_eff == ONE_CNT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          post_cnt_d = post_cnt_inc;
          if (post_cnt_inc == len_eff) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register reads use current state; buffer reads use the word fetched during the address phase.
  always_comb begin
    hrdata = '0;
    if (rd_en) begin
      if ((dph_off_q >> (DEPTH_LOG2 + 2)) == BUF_TAG) begin
        hrdata[DATA_W-1:0] = ram_rdata;
      end else begin
        case (dph_off_q)
          OFF_CTRL: begin
            hrdata[CTRL_IRQ_EN]    = irq_en_q;
            hrdata[CTRL_TRIG_MODE] = trig_mode_q;
          end
          OFF_STATUS: begin
            hrdata[2:0]         = state_q;
            hrdata[STATUS_DONE] = done_q;
          end
          OFF_THRESH:    hrdata[DATA_W-1:0] = thresh_q;
          OFF_LENGTH:    hrdata[CW-1:0]     = length_q;
          OFF_TRIG_ADDR: hrdata[AW-1:0]     = trig_addr_q;
          default:       hrdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tready_q     <= 1'b0;
      dph_valid_q  <= 1'b0;
      dph_write_q  <= 1'b0;
      dph_off_q    <= '0;
      irq_en_q     <= 1'b0;
      trig_mode_q  <= 1'b0;
      thresh_q     <= '0;
      length_q     <= '0;
      trig_addr_q  <= '0;
      done_q       <= 1'b0;
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      post_cnt_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      tready_q     <= tready_d;
      dph_valid_q  <= dph_valid_d;
      dph_write_q  <= dph_write_d;
      dph_off_q    <= dph_off_d;
      irq_en_q     <= irq_en_d;
      trig_mode_q  <= trig_mode_d;
      thresh_q     <= thresh_d;
      length_q     <= length_d;
      trig_addr_q  <= trig_addr_d;
      done_q       <= done_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      post_cnt_q   <= post_cnt_d;
      irq_q        <= irq_d;
    end
  end

  capture_ram #(
    .AW(AW),
    .DW(DATA_W)
  ) u_ram (
    .clk  (hclk),
    .we   (ram_we),
    .waddr(wr_ptr_q),
    .wdata(bus.tdata_s),
    .raddr(bus.haddr_s[AW+1:2]),
    .rdata(ram_rdata)
  );

  assign bus.tready_s    = tready_q;
  assign bus.hreadyout_s = 1'b1;
  assign bus.hresp_s     = 1'b0;
  assign bus.hrdata_s    = hrdata;
  assign irq             = irq_q;
endmodule

// File: tb/tb_stream_capture_buffer.sv
// tb/tb_stream_capture_buffer.sv - self-checking bench for stream_capture_buffer
module tb_stream_capture_buffer;
  localparam int DEPTH = 1024;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  bit   irq_exp = 1'b0;

  stream_capture_buffer_if #(.DATA_W(16)) bus ();

  stream_capture_buffer #(.DEPTH_LOG2(10), .DATA_W(16)) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus.slave),
    .irq    (irq)
  );

  always #5 hclk = ~hclk;

  // Behavioural model: the capture is the list of samples seen since START.
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_hist [$];
  bit          m_irq_en = 0, m_trig_mode = 0, m_done = 0, m_active = 0;
  logic [15:0] m_thresh = '0;
  logic [10:0] m_length = '0;
  int          m_trig_addr = 0;
  int          m_trig_idx = -1;

  function automatic int m_len_eff();
    return (m_length == 0 || m_length > 11'd1024) ? DEPTH : int'(m_length);
  endfunction

  function automatic logic [2:0] m_state();
    if (!m_active) return 3'd0;
    if (m_trig_idx < 0) return 3'd1;
    if (m_hist.size() >= m_trig_idx + m_len_eff()) return 3'd3;
    return 3'd2;
  endfunction

  task automatic m_sample(input logic [15:0] v);
    int n;
    bit hit;
    if (!m_active || m_state() == 3'd3) return;
    m_hist.push_back(v);
    n = m_hist.size();
    if (m_trig_idx < 0) begin
      if (m_trig_mode)
        hit = (n >= 2) && ($signed(m_hist[n-2]) < $signed(m_thresh)) && ($signed(v) >= $signed(m_thresh));
      else
        hit = (n == 1);
      if (hit) begin
        m_trig_idx  = n - 1;
        m_trig_addr = (n - 1) % DEPTH;
      end
    end
    m_mem[(n-1) % DEPTH]   = v;
    m_known[(n-1) % DEPTH] = 1'b1;
    if (m_trig_idx >= 0 && n == m_trig_idx + m_len_eff()) m_done = 1'b1;
  endtask

  task automatic m_write(input logic [31:0] a, input logic [31:0] d);
    case (a[12:0])
      13'h000: begin
        m_irq_en    = d[2];
        m_trig_mode = d[3];
        if (d[1]) m_active = 1'b0;
        else if (d[0]) begin
          m_active = 1'b1;
          m_hist.delete();
          m_trig_idx = -1;
          m_done = 1'b0;
        end
      end
      13'h004: if (d[4]) m_done = 1'b0;
      13'h008: m_thresh = d[15:0];
      13'h00C: m_length = d[10:0];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [12:0] off;
    int idx;
    off = a[12:0];
    known = 1'b1;
    if (off >= 13'h1000) begin
      idx = int'(off[11:2]);
      known = m_known[idx];
      return {16'h0, m_mem[idx]};
    end
    case (off)
      13'h000: return {28'h0, m_trig_mode, m_irq_en, 2'b00};
      13'h004: return {27'h0, m_done, 1'b0, m_state()};
      13'h008: return {16'h0, m_thresh};
      13'h00C: return {21'h0, m_length};
      13'h010: return 32'(m_trig_addr);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (cmp_en) begin
      chk("tready", 32'(bus.tready_s), 32'd1);
      chk("hreadyout", 32'(bus.hreadyout_s), 32'd1);
      chk("hresp", 32'(bus.hresp_s), 32'd0);
      chk("irq", 32'(irq), 32'(irq_exp));
      irq_exp = m_done & m_irq_en;
    end
  end

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b1; bus.haddr_s = a;
    @(posedge hclk); #1;
    bus.hsel_s = 1'b0; bus.htrans_s = 2'b00; bus.hwrite_s = 1'b0; bus.hwdata_s = d;
    @(posedge hclk);
    m_write(a, d);
    #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] r);
    bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b0; bus.haddr_s = a;
    @(posedge hclk); #1;
    bus.hsel_s = 1'b0; bus.htrans_s = 2'b00;
    @(negedge hclk);
    r = bus.hrdata_s;
    @(posedge hclk); #1;
  endtask

  task automatic rd(input string name, input logic [31:0] a, output logic [31:0] r);
    logic [31:0] e;
    bit kn;
    ahb_read(a, r);
    e = m_read(a, kn);
    if (kn) chk(name, r, e);
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] lit);
    logic [31:0] r;
    bit kn;
    rd(name, a, r);
    chk({name, "_lit"}, r, lit);
    chk({name, "_model"}, m_read(a, kn), lit);
  endtask

  task automatic send(input logic [15:0] v);
    bus.tvalid_s = 1'b1; bus.tdata_s = v;
    @(posedge hclk);
    m_sample(v);
    #1;
    bus.tvalid_s = 1'b0;
  endtask

  function automatic logic [31:0] sa(input int i);
    return 32'h1000 + 32'(4 * i);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bus.tdata_s = '0; bus.tvalid_s = 1'b0; bus.haddr_s = '0; bus.hburst_s = '0;
    bus.hsize_s = 3'd2; bus.htrans_s = '0; bus.hwdata_s = '0; bus.hwrite_s = 1'b0; bus.hsel_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    #12;
    chk("rst_tready", 32'(bus.tready_s), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_hrdata", bus.hrdata_s, 32'd0);
    chk("rst_hreadyout", 32'(bus.hreadyout_s), 32'd1);
    chk("rst_hresp", 32'(bus.hresp_s), 32'd0);
    #10 hresetn = 1'b1;
    @(posedge hclk); #1;
    cmp_en = 1'b1;
    rd_lit("rst_status", 32'h004, 32'h0);
    rd("rst_buf0", 32'h1000, r);

    // Prefill so that untouched indices have known content later.
    ahb_write(32'h00C, 32'd16);
    ahb_write(32'h000, 32'h5);
    for (int i = 0; i < 16; i++) send(16'h0200 + 16'(i));
    ahb_write(32'h004, 32'h10);

    ahb_write(32'h00C, 32'd8);
    ahb_write(32'h000, 32'h5);
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i));
    rd_lit("imm_trig_addr", 32'h010, 32'd0);
    rd_lit("imm_s0", sa(0), 32'h0100);
    rd_lit("imm_s7", sa(7), 32'h0107);
    rd_lit("imm_s8_kept", sa(8), 32'h0208);
    for (int i = 0; i < 10; i++) rd("imm_buf", sa(i), r);
    rd_lit("imm_status", 32'h004, 32'h13);
    chk("imm_irq_lit", 32'(irq), 32'd1);

    ahb_write(32'h008, 32'h0000);
    ahb_write(32'h00C, 32'd4);
    ahb_write(32'h000, 32'hD);
    send(16'hFFFD); send(16'hFFFE); send(16'hFFFF); send(16'h0000); send(16'h0001); send(16'h0002);
    rd_lit("lvl_status_post", 32'h004, 32'h02);
    send(16'h0003);
    rd_lit("lvl_status_done", 32'h004, 32'h13);
    send(16'h0004);
    rd_lit("lvl_trig_addr", 32'h010, 32'd3);
    for (int i = 0; i < 4; i++) rd_lit("lvl_post", sa(3 + i), 32'(i));
    rd_lit("lvl_s7_kept", sa(7), 32'h0107);
    for (int i = 0; i < 8; i++) rd("lvl_buf", sa(i), r);
    ahb_write(32'h004, 32'h10);
    rd_lit("clr_status", 32'h004, 32'h03);

    ahb_write(32'h000, 32'hD);
    for (int i = 0; i < 1030; i++) send(16'(5 + i));
    rd_lit("notrig_status", 32'h004, 32'h01);
    rd_lit("notrig_s0", sa(0), 32'd1029);
    rd_lit("notrig_s5", sa(5), 32'd1034);
    rd_lit("notrig_s6", sa(6), 32'd11);
    rd_lit("notrig_trig_addr", 32'h010, 32'd3);

    ahb_write(32'h000, 32'hD);
    for (int i = 0; i < 1022; i++) send(16'hFFFF);
    send(16'h0000); send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0007); send(16'h0008);
    rd_lit("wrap_trig_addr", 32'h010, 32'd1022);
    rd_lit("wrap_s1022", sa(1022), 32'h0);
    rd_lit("wrap_s1023", sa(1023), 32'h1);
    rd_lit("wrap_s0", sa(0), 32'h2);
    rd_lit("wrap_s1", sa(1), 32'h3);
    rd_lit("wrap_s2", sa(2), 32'hFFFF);
    rd_lit("wrap_status", 32'h004, 32'h13);

    ahb_write(32'h00C, 32'd1);
    ahb_write(32'h000, 32'h5);
    send(16'h1234); send(16'h5678);
    rd_lit("len1_status", 32'h004, 32'h13);
    rd_lit("len1_s0", sa(0), 32'h1234);
    rd_lit("len1_s1", sa(1), 32'h0003);

    ahb_write(32'h00C, 32'd0);
    ahb_write(32'h000, 32'h5);
    for (int i = 0; i < 1023; i++) send(16'h4000 + 16'(i));
    rd_lit("full_status_post", 32'h004, 32'h02);
    send(16'h43FF);
    rd_lit("full_status_done", 32'h004, 32'h13);
    rd_lit("full_s0", sa(0), 32'h4000);
    rd_lit("full_s1023", sa(1023), 32'h43FF);

    ahb_write(32'h000, 32'hD);
    send(16'h0005); send(16'h0006);
    rd_lit("abort_armed", 32'h004, 32'h01);
    ahb_write(32'h000, 32'h3);
    rd_lit("abort_status", 32'h004, 32'h00);
    ahb_write(32'h00C, 32'd1);
    ahb_write(32'h000, 32'h1);
    send(16'h0077);
    ahb_write(32'h000, 32'h2);
    rd_lit("abort_keep_done", 32'h004, 32'h10);
    rd_lit("abort_keep_ram", sa(0), 32'h0077);

    ahb_write(32'h00C, 32'd8);
    ahb_write(32'h000, 32'h1);
    send(16'h0011); send(16'h0022); send(16'h0033);
    rd_lit("rst_post", 32'h004, 32'h02);
    ahb_write(32'h000, 32'h1);
    rd_lit("restart_status", 32'h004, 32'h01);
    send(16'hAAAA);
    rd_lit("restart_trig_addr", 32'h010, 32'd0);
    rd_lit("restart_s0", sa(0), 32'hAAAA);
    rd_lit("restart_s1", sa(1), 32'h0022);
    rd_lit("restart_post", 32'h004, 32'h02);

    ahb_write(32'h1004, 32'hDEAD);
    rd_lit("buf_ro", sa(1), 32'h0022);
    ahb_write(32'h040, 32'hFFFF_FFFF);
    rd_lit("unmapped", 32'h040, 32'h0);
    ahb_write(32'h008, 32'h0001_2345);
    rd_lit("thresh_rb", 32'h008, 32'h2345);
    ahb_write(32'h00C, 32'hFFFF_FFFF);
    rd_lit("length_rb", 32'h00C, 32'h7FF);
    ahb_write(32'h000, 32'hF);
    rd_lit("ctrl_rb", 32'h000, 32'h0C);
    rd_lit("final_status", 32'h004, 32'h00);

    repeat (3) @(posedge hclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
